// File: rtl/uart_link_fifo_if.sv
// Parallel-side bundle of the UART endpoint.
// The TX push handshake and the RX result word travel together here.
// The serial lines tx_line and rx_line stay plain ports so that two
// endpoints can be cross-wired directly.
interface uart_link_fifo_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_busy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_parity_err;
    logic              rx_frame_err;

    // Host side: offers words to send and consumes received words.
    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy,
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    // UART endpoint side.
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy,
        output rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_link_fifo.sv
// Full-duplex UART endpoint.
// TX side: a FIFO feeds a frame serialiser that sends frames back to back.
// RX side: a 2-flop synchroniser feeds a mid-bit sampling deserialiser
// that reports parity and framing errors.
// Frame format: start(0), DATA_W bits LSB first, optional parity bit, one stop(1).
module uart_link_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_link_fifo_if.slave   bus,
    output logic              tx_line,
    input  logic              rx_line
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 2);

    // Parity bit that accompanies a data word: even -> XOR of bits, odd -> its inverse.
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    fifo_cnt_q, fifo_cnt_d;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_ready;
    logic [DATA_W-1:0] fifo_head;

    assign fifo_ready = (fifo_cnt_q != FIFO_FULL);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_push  = bus.tx_valid && fifo_ready;
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    // Storage array; no reset so it maps onto RAM, the pointers define validity.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    // Pointer and occupancy update; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_t;

    tx_state_t         tx_state_q, tx_state_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_line_q, tx_line_d;

    // Frame sequencing; tx_line is computed one step ahead so the pin comes straight from a flop.
    // A frame starts on the same edge the word leaves the FIFO, so back-to-back frames have no gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = fifo_head;
                    tx_par_d   = parity_of(fifo_head);
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BIT_LAST) begin
                        if (PAR_EN) begin
                            tx_state_d = TX_PAR;
                            tx_line_d  = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_PAR: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_state_d = TX_START;
                        tx_shift_d = fifo_head;
                        tx_par_d   = parity_of(fifo_head);
                        tx_line_d  = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_line_d  = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // TX state registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign tx_line      = tx_line_q;
    assign bus.tx_ready = fifo_ready;
    assign bus.tx_busy  = (tx_state_q != TX_IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // RX synchroniser and deserialiser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    // Two-flop synchroniser; resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_line;
            rx_sync_q <= rx_meta_q;
        end
    end

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_par_q, rx_par_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_perr_q, rx_perr_d;
    logic              rx_ferr_q, rx_ferr_d;

    // Frame reception: recheck the start bit at half a bit, then sample once per bit period.
    // After a framing error, wait for the line to go high so a held-low line cannot start a frame.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = '0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = PAR_EN ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_PAR: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = PAR_EN && (rx_par_q != parity_of(rx_shift_q));
                    rx_ferr_d  = !rx_sync_q;
                    rx_valid_d = 1'b1;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX state and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;

endmodule
